// File: rtl/n2_dva_wr_ctl.sv
// Write-port controller for the 32x32 dirty/valid array. It queues masked update
// requests, runs the flash-invalidate sweep, and drives the array write port from registers.
module n2_dva_wr_ctl #(
  parameter int DEPTH   = 4,
  parameter int ENTRIES = 32,
  parameter int AW      = 5,
  parameter int DW      = 32
) (
  input  logic          l2clk,
  input  logic          rst,
  input  logic          tcu_array_wr_inhibit,
  input  logic          req_vld,
  input  logic [AW-1:0] req_idx,
  input  logic [DW-1:0] req_data,
  input  logic [DW-1:0] req_mask,
  output logic          req_rdy,
  input  logic          flash_req,
  output logic          flash_busy,
  output logic          flash_done,
  output logic          flash_ign,
  output logic          arr_wr_en,
  output logic [AW-1:0] arr_wr_addr,
  output logic [DW-1:0] arr_din,
  output logic [DW-1:0] arr_bit_wen
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = AW + 1;
  localparam int EW = AW + 2 * DW;

  typedef enum logic [1:0] {IDLE, FLASH, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   fidx_q, fidx_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d, wen_q, wen_d;
  logic            ign_q, ign_d;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic            full, empty, push, pop, flush;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign req_rdy = !full;
  assign push    = req_vld && !full;
  assign head    = mem[rptr_q];

  always_ff @(posedge l2clk) begin
    if (push) mem[wptr_q] <= {req_idx, req_data, req_mask};
  end

  always_comb begin
    state_d = state_q;
    fidx_d  = fidx_q;
    pop     = 1'b0;
    flush   = 1'b0;
    wr_en_d = 1'b0;
    addr_d  = '0;
    din_d   = '0;
    wen_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (flash_req) begin
          state_d = FLASH;
          flush   = 1'b1;
          fidx_d  = '0;
        end else if (!empty && !tcu_array_wr_inhibit) begin
          pop     = 1'b1;
          wr_en_d = 1'b1;
          addr_d  = head[EW-1 -: AW];
          din_d   = head[2*DW-1 -: DW];
          wen_d   = head[DW-1:0];
        end
      end
      FLASH: begin
        // fidx reaching ENTRIES means the last write is already on the port.
        if (!tcu_array_wr_inhibit) begin
          if (fidx_q == IW'(ENTRIES)) begin
            state_d = DONE;
          end else begin
            wr_en_d = 1'b1;
            addr_d  = fidx_q[AW-1:0];
            wen_d   = '1;
            fidx_d  = fidx_q + IW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        fidx_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush keeps only a request pushed in the same cycle.
  assign ign_d  = flash_req && (state_q != IDLE);
  assign wptr_d = wptr_q + PW'(push);
  assign rptr_d = flush ? wptr_q : rptr_q + PW'(pop);
  assign cnt_d  = flush ? CW'(push) : cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge l2clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      fidx_q  <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      wen_q   <= '0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wen_q   <= wen_d;
      ign_q   <= ign_d;
    end
  end

  assign flash_busy  = (state_q == FLASH);
  assign flash_done  = (state_q == DONE);
  assign flash_ign   = ign_q;
  assign arr_wr_en   = wr_en_q;
  assign arr_wr_addr = addr_q;
  assign arr_din     = din_q;
  assign arr_bit_wen = wen_q;

endmodule
